// File: rtl/onc_boot_ctrl_pkg.sv
// Shared definitions for the ONC-16 boot/run controller.
// Holds the core word widths, the controller state encodings and a
// header-length check helper used by the loader.
package onc_boot_ctrl_pkg;

  localparam int DATA_W     = 16;
  localparam int INST_W     = 16;
  localparam int BC_STATE_W = 3;

  typedef enum logic [BC_STATE_W-1:0] {
    BC_IDLE   = 3'd0,
    BC_HDR    = 3'd1,
    BC_LOAD   = 3'd2,
    BC_RSTCPU = 3'd3,
    BC_RUN    = 3'd4,
    BC_HALT   = 3'd5
  } bc_state_e;

  // A header length is unusable when it is zero or larger than the memory.
  function automatic logic bc_len_bad(input logic [31:0] len, input logic [31:0] depth);
    return (len == 32'd0) || (len > depth);
  endfunction

endpackage

// File: rtl/bc_halt_det.sv
// Halt detector and run-cycle counter for the ONC-16 boot controller.
// Ports:
//   clock, rst      : clock and asynchronous active-high reset
//   i_run           : controller is in RUN this cycle
//   i_clr           : accepted start; clears the cycle counter
//   i_pc            : core fetch address
//   o_halt_hit      : PC repeated the value captured on the previous RUN edge
//   o_cycle_cnt     : saturating count of RUN edges of the current/last run
module bc_halt_det #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              i_run,
  input  logic              i_clr,
  input  logic [DATA_W-1:0] i_pc,
  output logic              o_halt_hit,
  output logic [CNT_W-1:0]  o_cycle_cnt
);

  logic [DATA_W-1:0] r_prev_pc;
  logic              r_pv;
  logic [CNT_W-1:0]  r_cnt;

  // A branch-to-self shows up as the same fetch address on two RUN cycles in a row.
  assign o_halt_hit  = r_pv && (i_pc == r_prev_pc);
  assign o_cycle_cnt = r_cnt;

  // Capture the previous PC during RUN; the valid flag drops whenever RUN is left.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_prev_pc <= '0;
      r_pv      <= 1'b0;
    end else if (i_run) begin
      r_prev_pc <= i_pc;
      r_pv      <= 1'b1;
    end else begin
      r_pv      <= 1'b0;
    end
  end

  // Count every RUN edge, including the exit edge, saturating at all-ones.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_run && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/onc_boot_ctrl.sv
// Boot and run controller for the ONC-16 core.
// Loads a length-prefixed program image from the host word stream into
// instruction memory while holding the core in reset, then runs the core
// until it branches to itself or the host raises stop.
// Ports:
//   clock, rst                     : clock, asynchronous active-high reset
//   start, stop                    : host load request pulse / run stop level
//   host_valid, host_data, host_ready : host word stream handshake
//   imem_we, imem_waddr, imem_wdata   : instruction memory write port
//   cpu_pc                         : core fetch address
//   cpu_n_rst, cpu_en              : core reset (active low) and enable
//   busy, halted, err, cycle_cnt   : status to the host
module onc_boot_ctrl #(
  parameter int DATA_W  = 16,
  parameter int IMEM_AW = 8,
  parameter int CNT_W   = 32
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               host_valid,
  input  logic [DATA_W-1:0]  host_data,
  output logic               host_ready,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_waddr,
  output logic [DATA_W-1:0]  imem_wdata,
  input  logic [DATA_W-1:0]  cpu_pc,
  output logic               cpu_n_rst,
  output logic               cpu_en,
  output logic               busy,
  output logic               halted,
  output logic               err,
  output logic [CNT_W-1:0]   cycle_cnt
);
  import onc_boot_ctrl_pkg::*;

  localparam int DEPTH = 2**IMEM_AW;
  localparam int RW    = IMEM_AW + 1;

  bc_state_e        r_state;
  bc_state_e        w_next;
  logic [RW-1:0]    r_remaining;
  logic [IMEM_AW-1:0] r_waddr;
  logic             w_hs;
  logic             w_start_ok;
  logic             w_len_bad;
  logic             w_halt_hit;
  logic             w_n_rst_d;
  logic             w_en_d;
  logic             w_busy_d;
  logic             w_halted_d;

  assign host_ready = (r_state == BC_HDR) || (r_state == BC_LOAD);
  assign w_hs       = host_valid && host_ready;
  assign w_start_ok = start && ((r_state == BC_IDLE) || (r_state == BC_HALT));
  assign w_len_bad  = bc_len_bad(32'(host_data), 32'(DEPTH));

  bc_halt_det #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_halt_det (
    .clock       (clock),
    .rst         (rst),
    .i_run       (r_state == BC_RUN),
    .i_clr       (w_start_ok),
    .i_pc        (cpu_pc),
    .o_halt_hit  (w_halt_hit),
    .o_cycle_cnt (cycle_cnt)
  );

  // State register.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state <= BC_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      BC_IDLE: begin
        if (start) w_next = BC_HDR;
        else       w_next = BC_IDLE;
      end
      BC_HDR: begin
        if (w_hs && w_len_bad) w_next = BC_IDLE;
        else if (w_hs)         w_next = BC_LOAD;
        else                   w_next = BC_HDR;
      end
      BC_LOAD: begin
        if (w_hs && (r_remaining == RW'(1))) w_next = BC_RSTCPU;
        else                                 w_next = BC_LOAD;
      end
      BC_RSTCPU: w_next = BC_RUN;
      BC_RUN: begin
        // stop and self-loop both end the run; stop is listed first
        if (stop)            w_next = BC_HALT;
        else if (w_halt_hit) w_next = BC_HALT;
        else                 w_next = BC_RUN;
      end
      BC_HALT: begin
        if (start) w_next = BC_HDR;
        else       w_next = BC_HALT;
      end
      default: w_next = BC_IDLE;
    endcase
  end

  // Output decode from the next state so the registered pins line up with the state.
  always_comb begin
    w_n_rst_d  = 1'b0;
    w_en_d     = 1'b0;
    w_busy_d   = 1'b0;
    w_halted_d = 1'b0;
    case (w_next)
      BC_HDR, BC_LOAD, BC_RSTCPU: w_busy_d = 1'b1;
      BC_RUN: begin
        w_n_rst_d = 1'b1;
        w_en_d    = 1'b1;
        w_busy_d  = 1'b1;
      end
      BC_HALT: begin
        w_n_rst_d  = 1'b1;
        w_halted_d = 1'b1;
      end
      default: w_busy_d = 1'b0;
    endcase
  end

  // Registered core control and status pins.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      cpu_n_rst <= 1'b0;
      cpu_en    <= 1'b0;
      busy      <= 1'b0;
      halted    <= 1'b0;
    end else begin
      cpu_n_rst <= w_n_rst_d;
      cpu_en    <= w_en_d;
      busy      <= w_busy_d;
      halted    <= w_halted_d;
    end
  end

  // Loader: header capture, word counting and the delayed memory write.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_remaining <= '0;
      r_waddr     <= '0;
      imem_we     <= 1'b0;
      imem_waddr  <= '0;
      imem_wdata  <= '0;
      err         <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      if (w_start_ok) begin
        err <= 1'b0;
      end else if (w_hs && (r_state == BC_HDR) && w_len_bad) begin
        err <= 1'b1;
      end else begin
        err <= err;
      end
      if (w_hs && (r_state == BC_HDR)) begin
        // truncation is harmless: oversize lengths never reach LOAD
        r_remaining <= RW'(host_data);
        r_waddr     <= '0;
      end else if (w_hs && (r_state == BC_LOAD)) begin
        imem_we     <= 1'b1;
        imem_waddr  <= r_waddr;
        imem_wdata  <= host_data;
        // a full-depth image wraps the address back to 0, which is unused
        r_waddr     <= r_waddr + IMEM_AW'(1);
        r_remaining <= r_remaining - RW'(1);
      end else begin
        r_remaining <= r_remaining;
        r_waddr     <= r_waddr;
      end
    end
  end

endmodule

// File: tb/tb_onc_boot_ctrl.sv
module tb_onc_boot_ctrl;
  localparam int DATA_W  = 16;
  localparam int IMEM_AW = 8;
  localparam int CNT_W   = 32;
  localparam int DEPTH   = 2**IMEM_AW;

  logic               clock = 1'b0;
  logic               rst;
  logic               start;
  logic               stop;
  logic               host_valid;
  logic [DATA_W-1:0]  host_data;
  logic               host_ready;
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_waddr;
  logic [DATA_W-1:0]  imem_wdata;
  logic [DATA_W-1:0]  cpu_pc;
  logic               cpu_n_rst;
  logic               cpu_en;
  logic               busy;
  logic               halted;
  logic               err;
  logic [CNT_W-1:0]   cycle_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] img[$];

  onc_boot_ctrl #(.DATA_W(DATA_W), .IMEM_AW(IMEM_AW), .CNT_W(CNT_W)) dut (
    .clock(clock), .rst(rst), .start(start), .stop(stop),
    .host_valid(host_valid), .host_data(host_data), .host_ready(host_ready),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .cpu_pc(cpu_pc), .cpu_n_rst(cpu_n_rst), .cpu_en(cpu_en),
    .busy(busy), .halted(halted), .err(err), .cycle_cnt(cycle_cnt)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("start_ready", 32'(host_ready), 32'd1);
    check_val("hdr_n_rst", 32'(cpu_n_rst), 32'd0);
    check_val("hdr_en", 32'(cpu_en), 32'd0);
    check_val("hdr_busy", 32'(busy), 32'd1);
    check_val("hdr_err_clr", 32'(err), 32'd0);
    check_val("hdr_cnt_clr", cycle_cnt, 32'd0);
  endtask

  // Load img[] with random host stalls (gap_at forces one stall before that word).
  task automatic load_image(input int gap_pct, input int gap_at);
    do_start();
    host_valid = 1'b1;
    host_data  = 16'(img.size());
    tick();
    check_val("load_ready", 32'(host_ready), 32'd1);
    check_val("hdr_no_we", 32'(imem_we), 32'd0);
    for (int i = 0; i < img.size(); i++) begin
      if ((i == gap_at) || (int'($urandom_range(99, 0)) < gap_pct)) begin
        host_valid = 1'b0;
        host_data  = 16'($urandom);
        stop       = 1'($urandom);
        start      = 1'($urandom);
        tick();
        check_val("gap_no_we", 32'(imem_we), 32'd0);
      end
      host_valid = 1'b1;
      host_data  = img[i];
      stop       = 1'b0;
      start      = 1'b0;
      tick();
      check_val("wr_we", 32'(imem_we), 32'd1);
      check_val("wr_addr", 32'(imem_waddr), 32'(i % DEPTH));
      check_val("wr_data", 32'(imem_wdata), 32'(img[i]));
    end
    host_valid = 1'b0;
    check_val("rstcpu_ready", 32'(host_ready), 32'd0);
    check_val("rstcpu_n_rst", 32'(cpu_n_rst), 32'd0);
    check_val("rstcpu_en", 32'(cpu_en), 32'd0);
    tick();
    check_val("run_en", 32'(cpu_en), 32'd1);
    check_val("run_n_rst", 32'(cpu_n_rst), 32'd1);
    check_val("run_no_we", 32'(imem_we), 32'd0);
  endtask

  // Core model: PC counts 0,1,.. up to loop_at then stays there.
  // The first repeat is on RUN cycle loop_at+2, so that many edges are counted;
  // a stop on cycle stop_at (0 = none) ends the run earlier if it comes first.
  task automatic run_core(input int loop_at, input int stop_at, input int ign_start_at);
    int exp_cnt;
    int c;
    bit done;
    exp_cnt = loop_at + 2;
    if ((stop_at > 0) && (stop_at < exp_cnt)) exp_cnt = stop_at;
    c = 0;
    done = 1'b0;
    while (!done && (c < 2000)) begin
      c++;
      cpu_pc = 16'((c - 1 < loop_at) ? c - 1 : loop_at);
      stop   = (c == stop_at);
      start  = (c == ign_start_at);
      tick();
      if (halted === 1'b1) done = 1'b1;
    end
    stop  = 1'b0;
    start = 1'b0;
    check_val("halt_reached", 32'(done), 32'd1);
    check_val("run_edges", 32'(c), 32'(exp_cnt));
    check_val("cycle_cnt", cycle_cnt, 32'(exp_cnt));
    check_val("halt_en", 32'(cpu_en), 32'd0);
    check_val("halt_n_rst", 32'(cpu_n_rst), 32'd1);
    check_val("halt_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 3; k++) begin
      cpu_pc = 16'($urandom);
      stop   = 1'($urandom);
      tick();
      check_val("halt_hold_cnt", cycle_cnt, 32'(exp_cnt));
      check_val("halt_hold", 32'(halted), 32'd1);
    end
    stop   = 1'b0;
    cpu_pc = 16'd0;
  endtask

  task automatic bad_len(input logic [15:0] len);
    do_start();
    host_valid = 1'b1;
    host_data  = len;
    tick();
    host_valid = 1'b0;
    check_val("bad_err", 32'(err), 32'd1);
    check_val("bad_idle_ready", 32'(host_ready), 32'd0);
    check_val("bad_busy", 32'(busy), 32'd0);
    check_val("bad_no_we", 32'(imem_we), 32'd0);
    check_val("bad_n_rst", 32'(cpu_n_rst), 32'd0);
    tick();
    check_val("bad_err_sticky", 32'(err), 32'd1);
    check_val("bad_no_we2", 32'(imem_we), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_ready"}, 32'(host_ready), 32'd0);
    check_val({tag, "_we"}, 32'(imem_we), 32'd0);
    check_val({tag, "_waddr"}, 32'(imem_waddr), 32'd0);
    check_val({tag, "_wdata"}, 32'(imem_wdata), 32'd0);
    check_val({tag, "_n_rst"}, 32'(cpu_n_rst), 32'd0);
    check_val({tag, "_en"}, 32'(cpu_en), 32'd0);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_halted"}, 32'(halted), 32'd0);
    check_val({tag, "_err"}, 32'(err), 32'd0);
    check_val({tag, "_cnt"}, cycle_cnt, 32'd0);
  endtask

  initial begin
    int len;
    rst = 1'b1; start = 1'b0; stop = 1'b0; host_valid = 1'b0;
    host_data = 16'd0; cpu_pc = 16'd0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check_reset_vals("rst");

    // Three-word image with one stall, then a self-loop at address 0.
    img = {16'h1111, 16'h2222, 16'h3333};
    load_image(0, 1);
    run_core(0, 0, 0);

    // One-word image, self-loop at 0, reloaded from HALT.
    img = {16'($urandom)};
    load_image(0, -1);
    run_core(0, 0, 1);

    // Bad lengths from HALT and IDLE; each following start clears err.
    bad_len(16'd0);
    bad_len(16'd257);
    bad_len(16'($urandom_range(65535, 258)));

    // Reset in the middle of a load.
    do_start();
    host_valid = 1'b1;
    host_data  = 16'd5;
    tick();
    host_data  = 16'hABCD;
    tick();
    tick();
    host_valid = 1'b0;
    #1 rst = 1'b1;
    #1 check_reset_vals("midload_rst");
    tick();
    rst = 1'b0;
    tick();
    check_reset_vals("post_rst");

    // Host stop on the 10th RUN cycle with an ignored start during RUN.
    img.delete();
    for (int i = 0; i < 4; i++) img.push_back(16'($urandom));
    load_image(30, -1);
    run_core(1000, 10, 4);

    // Full-depth image.
    img.delete();
    for (int i = 0; i < DEPTH; i++) img.push_back(16'($urandom));
    load_image(10, -1);
    run_core(int'($urandom_range(20, 0)), 0, 0);

    // Randomized images and run lengths.
    for (int t = 0; t < 6; t++) begin
      len = int'($urandom_range(40, 1));
      img.delete();
      for (int i = 0; i < len; i++) img.push_back(16'($urandom));
      load_image(25, -1);
      run_core(int'($urandom_range(40, 0)),
               ($urandom_range(1, 0) == 1) ? int'($urandom_range(50, 1)) : 0,
               int'($urandom_range(2, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
